// File: rtl/mic_frame_writer.sv
// mic_frame_writer: captures one frame of DEPTH streamed samples into a
// single-port RAM write interface. start arms a capture, abort cancels it,
// frame_done pulses once the last sample's write is presented to the RAM.
// DEPTH must equal 2**AW so the address counter covers the frame exactly.
module mic_frame_writer #(
  parameter int DW    = 16,
  parameter int AW    = 9,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          ram_cea,
  output logic [AW-1:0] ram_ada,
  output logic [DW-1:0] ram_din,
  output logic          busy,
  output logic          frame_done,
  output logic [AW:0]   wr_count,
  output logic          overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // wr_count value at which the next acceptance is the last of the frame
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_ram_cea;
  logic [AW-1:0] r_ram_ada;
  logic [DW-1:0] r_ram_din;
  logic [AW:0]   r_wr_count;
  logic          r_overrun;

  logic          w_ready;
  logic          w_accept;
  logic          w_last;
  logic          w_enter_cap;

  assign w_ready     = (r_state == ST_CAPTURE);
  assign w_accept    = s_valid & w_ready;
  assign w_last      = w_accept && (r_wr_count == LAST_IDX);
  assign w_enter_cap = (r_state == ST_IDLE) && start && !abort;

  // State register
  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: abort beats completion; DONE always lasts one cycle
  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start && !abort) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort)       w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State-decoded outputs
  always_comb begin
    s_ready    = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (r_state)
      ST_CAPTURE: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      ST_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: begin
        s_ready    = 1'b0;
      end
    endcase
  end

  // RAM write port: one registered write per accepted sample; address/data hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_cea <= 1'b0;
      r_ram_ada <= '0;
      r_ram_din <= '0;
    end else begin
      r_ram_cea <= w_accept;
      if (w_accept) begin
        r_ram_ada <= r_wr_count[AW-1:0];
        r_ram_din <= s_data;
      end
    end
  end

  // Frame progress and sticky overrun; entering CAPTURE clears both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_count <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_enter_cap) begin
        r_wr_count <= '0;
        r_overrun  <= 1'b0;
      end else begin
        if (w_accept)            r_wr_count <= r_wr_count + 1'b1;
        if (s_valid && !w_ready) r_overrun  <= 1'b1;
      end
    end
  end

  assign ram_cea  = r_ram_cea;
  assign ram_ada  = r_ram_ada;
  assign ram_din  = r_ram_din;
  assign wr_count = r_wr_count;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_mic_frame_writer.sv
// Testbench for mic_frame_writer: directed scenarios plus a random run, all
// compared against a frame-level reference model kept in this bench.
module tb_mic_frame_writer;

  localparam int DW    = 16;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          ram_cea;
  logic [AW-1:0] ram_ada;
  logic [DW-1:0] ram_din;
  logic          busy;
  logic          frame_done;
  logic [AW:0]   wr_count;
  logic          overrun;

  int n_checks = 0;
  int n_errors = 0;

  mic_frame_writer #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .ram_cea    (ram_cea),
    .ram_ada    (ram_ada),
    .ram_din    (ram_din),
    .busy       (busy),
    .frame_done (frame_done),
    .wr_count   (wr_count),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Tracks the frame as "phase" (idle / capturing / completing), the number
  // of samples taken, the sticky overrun flag and the last write presented.
  typedef enum {PH_IDLE, PH_CAPTURING, PH_COMPLETING} phase_t;

  phase_t        m_phase;
  int            m_count;
  bit            m_ovr;
  bit            m_cea;
  int            m_ada;
  logic [DW-1:0] m_din;

  always @(posedge clk or negedge rst_n) begin : model
    bit     taken;
    int     cnt;
    bit     ovr;
    phase_t ph;
    if (!rst_n) begin
      m_phase <= PH_IDLE;
      m_count <= 0;
      m_ovr   <= 1'b0;
      m_cea   <= 1'b0;
      m_ada   <= 0;
      m_din   <= '0;
    end else begin
      taken = s_valid && (m_phase == PH_CAPTURING);
      cnt   = m_count + (taken ? 1 : 0);
      ovr   = m_ovr || (s_valid && (m_phase != PH_CAPTURING));
      ph    = m_phase;
      if (m_phase == PH_IDLE) begin
        if (start && !abort) begin
          ph  = PH_CAPTURING;
          cnt = 0;
          ovr = 1'b0;
        end
      end else if (m_phase == PH_CAPTURING) begin
        if (abort)             ph = PH_IDLE;
        else if (cnt == DEPTH) ph = PH_COMPLETING;
      end else begin
        ph = PH_IDLE;
      end
      m_cea <= taken;
      if (taken) begin
        m_ada <= m_count;
        m_din <= s_data;
      end
      m_count <= cnt;
      m_ovr   <= ovr;
      m_phase <= ph;
    end
  end

  // Cycle monitor: every output compared against the model mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (s_ready !== (m_phase == PH_CAPTURING)) begin
        n_errors++;
        $display("FAIL mon_s_ready t=%0t: got %b expected %b", $time, s_ready, m_phase == PH_CAPTURING);
      end
      n_checks++;
      if (busy !== (m_phase != PH_IDLE)) begin
        n_errors++;
        $display("FAIL mon_busy t=%0t: got %b expected %b", $time, busy, m_phase != PH_IDLE);
      end
      n_checks++;
      if (frame_done !== (m_phase == PH_COMPLETING)) begin
        n_errors++;
        $display("FAIL mon_frame_done t=%0t: got %b expected %b", $time, frame_done, m_phase == PH_COMPLETING);
      end
      n_checks++;
      if (wr_count !== (AW+1)'(m_count)) begin
        n_errors++;
        $display("FAIL mon_wr_count t=%0t: got %0d expected %0d", $time, wr_count, m_count);
      end
      n_checks++;
      if (overrun !== m_ovr) begin
        n_errors++;
        $display("FAIL mon_overrun t=%0t: got %b expected %b", $time, overrun, m_ovr);
      end
      n_checks++;
      if (ram_cea !== m_cea) begin
        n_errors++;
        $display("FAIL mon_ram_cea t=%0t: got %b expected %b", $time, ram_cea, m_cea);
      end
      n_checks++;
      if (ram_ada !== AW'(m_ada)) begin
        n_errors++;
        $display("FAIL mon_ram_ada t=%0t: got %0d expected %0d", $time, ram_ada, m_ada);
      end
      n_checks++;
      if (ram_din !== m_din) begin
        n_errors++;
        $display("FAIL mon_ram_din t=%0t: got %h expected %h", $time, ram_din, m_din);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    n_checks++;
    if ({s_ready, ram_cea, ram_ada, ram_din, busy, frame_done, wr_count, overrun} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got cea=%b ada=%0d din=%h busy=%b done=%b cnt=%0d ovr=%b rdy=%b expected all 0",
               ram_cea, ram_ada, ram_din, busy, frame_done, wr_count, overrun, s_ready);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_overrun();
    s_valid = 1'b1;
    s_data  = 16'h7FFF;
    tick();
    idle_inputs();
    n_checks++;
    if (ram_cea !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_no_write: got ram_cea=%b expected 0", ram_cea);
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_errors++;
      $display("FAIL idle_overrun: got %b expected 1", overrun);
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL start_abort_idle: got busy=%b s_ready=%b expected 0/0", busy, s_ready);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || wr_count !== 0) begin
      n_errors++;
      $display("FAIL b2b_entry_clear: got overrun=%b wr_count=%0d expected 0/0", overrun, wr_count);
    end
    for (int k = 0; k < DEPTH; k++) begin
      s_valid = 1'b1;
      s_data  = DW'(k);
      tick();
      if (k == DEPTH - 1) s_valid = 1'b0;
      n_checks++;
      if (ram_cea !== 1'b1 || ram_ada !== AW'(k) || ram_din !== DW'(k)) begin
        n_errors++;
        $display("FAIL b2b_write k=%0d: got cea=%b ada=%0d din=%h expected 1/%0d/%h", k, ram_cea, ram_ada, ram_din, k, k);
      end
      n_checks++;
      if (frame_done !== (k == DEPTH - 1)) begin
        n_errors++;
        $display("FAIL b2b_frame_done k=%0d: got %b expected %b", k, frame_done, k == DEPTH - 1);
      end
    end
    n_checks++;
    if (wr_count !== DEPTH) begin
      n_errors++;
      $display("FAIL b2b_wr_count: got %0d expected %0d", wr_count, DEPTH);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || ram_cea !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_after_done: got busy=%b done=%b cea=%b expected 0/0/0", busy, frame_done, ram_cea);
    end
  endtask

  task automatic test_gapped();
    logic [DW-1:0] q[$];
    int            writes;
    int            done_at;
    logic [DW-1:0] exp_d;
    writes  = 0;
    done_at = -1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int i = 0; i < 2 * DEPTH - 1; i++) begin
      s_valid = (i % 2 == 0);
      s_data  = DW'($urandom);
      if (s_valid) q.push_back(s_data);
      tick();
      s_valid = 1'b0;
      if (ram_cea === 1'b1) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 'x;
        n_checks++;
        if (ram_ada !== AW'(writes) || ram_din !== exp_d) begin
          n_errors++;
          $display("FAIL gap_write n=%0d: got ada=%0d din=%h expected %0d/%h", writes, ram_ada, ram_din, writes, exp_d);
        end
        writes++;
      end
      if (frame_done === 1'b1 && done_at < 0) done_at = i + 1;
    end
    n_checks++;
    if (writes !== DEPTH) begin
      n_errors++;
      $display("FAIL gap_write_total: got %0d expected %0d", writes, DEPTH);
    end
    n_checks++;
    if (done_at !== 2 * DEPTH - 1) begin
      n_errors++;
      $display("FAIL gap_done_cycle: got %0d expected %0d", done_at, 2 * DEPTH - 1);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL gap_overrun: got %b expected 0", overrun);
    end
    tick();
  endtask

  task automatic test_abort();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      tick();
    end
    s_valid = 1'b0;
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_to_idle: got busy=%b s_ready=%b expected 0/0", busy, s_ready);
    end
    n_checks++;
    if (wr_count !== 100) begin
      n_errors++;
      $display("FAIL abort_wr_count: got %0d expected 100", wr_count);
    end
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_no_done: got %b expected 0", frame_done);
    end
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    n_checks++;
    if (overrun !== 1'b1 || ram_cea !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_overrun: got overrun=%b cea=%b expected 1/0", overrun, ram_cea);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || wr_count !== 0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_restart: got overrun=%b wr_count=%0d busy=%b expected 0/0/1", overrun, wr_count, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, ram_cea, ram_ada, ram_din, busy, frame_done, wr_count, overrun} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_async: got cea=%b ada=%0d din=%h busy=%b cnt=%0d ovr=%b expected all 0",
               ram_cea, ram_ada, ram_din, busy, wr_count, overrun);
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_first_start: got busy=%b expected 1", busy);
    end
    for (int k = 0; k < DEPTH; k++) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      tick();
      if (k == 0) begin
        n_checks++;
        if (ram_cea !== 1'b1 || ram_ada !== '0) begin
          n_errors++;
          $display("FAIL reset_restart_addr: got cea=%b ada=%0d expected 1/0", ram_cea, ram_ada);
        end
      end
    end
    s_valid = 1'b0;
    tick();
  endtask

  task automatic test_start_ignored();
    int dones;
    dones = 0;
    start = 1'b1;
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      start   = (k == 200);
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      tick();
      if (frame_done === 1'b1) dones++;
    end
    s_valid = 1'b0;
    start   = 1'b1;
    n_checks++;
    if (ram_ada !== AW'(DEPTH - 1)) begin
      n_errors++;
      $display("FAIL restart_last_addr: got %0d expected %0d", ram_ada, DEPTH - 1);
    end
    tick();
    start = 1'b0;
    if (frame_done === 1'b1) dones++;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL restart_in_done: got busy=%b expected 0", busy);
    end
    tick();
    if (frame_done === 1'b1) dones++;
    n_checks++;
    if (dones !== 1) begin
      n_errors++;
      $display("FAIL restart_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(99) < 5);
      abort   = ($urandom_range(999) < 2);
      s_valid = ($urandom_range(99) < 70);
      s_data  = DW'($urandom);
      tick();
    end
    idle_inputs();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL random_end_idle: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_idle_overrun();
    test_back_to_back();
    test_gapped();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    test_random();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mic_frame_writer.md
MIC_FRAME_WRITER -- requirements
Module: mic_frame_writer

Interface
REQ-001 Parameter DW, default 16, sample and RAM data width in bits.
REQ-002 Parameter AW, default 9, RAM address width in bits.
REQ-003 Parameter DEPTH, default 512, samples per frame; DEPTH SHALL equal 2**AW.
REQ-004 clk  input  1  single clock for all logic and for the RAM write port.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse that arms capture of one frame.
REQ-007 abort  input  1  one-cycle pulse that cancels an in-progress capture.
REQ-008 s_valid  input  1  upstream sample valid.
REQ-009 s_data  input  DW  upstream signed sample.
REQ-010 s_ready  output  1  block accepts a sample this cycle.
REQ-011 ram_cea  output  1  RAM write-port clock enable.
REQ-012 ram_ada  output  AW  RAM write address.
REQ-013 ram_din  output  DW  RAM write data.
REQ-014 busy  output  1  capture in progress.
REQ-015 frame_done  output  1  one-cycle pulse when a full frame is written.
REQ-016 wr_count  output  AW+1  samples written in the current or last frame.
REQ-017 overrun  output  1  sticky flag: sample offered while not accepting.

Function
REQ-018 State machine SHALL have exactly three states: IDLE, CAPTURE, DONE.
REQ-019 IDLE -> CAPTURE on start=1 and abort=0; start and abort both 1 in IDLE keep IDLE.
REQ-020 Entering CAPTURE SHALL clear wr_count to 0 and overrun to 0 on the same edge.
REQ-021 s_ready SHALL be 1 exactly when state is CAPTURE; s_ready is combinational from state only.
REQ-022 Sample accepted on edge n (s_valid & s_ready) -> ram_cea=1, ram_ada=wr_count before increment, ram_din=s_data during cycle n+1; all three outputs registered.
REQ-023 ram_cea SHALL be 0 in every cycle not following an acceptance; ram_ada/ram_din hold last values when ram_cea=0.
REQ-024 wr_count SHALL increment by 1 per accepted sample and never exceed DEPTH.
REQ-025 Acceptance of sample index DEPTH-1 SHALL move CAPTURE -> DONE on the same edge; wr_count = DEPTH.
REQ-026 DONE SHALL last exactly one cycle, assert frame_done=1 in that cycle (coinciding with the final ram_cea=1), then -> IDLE.
REQ-027 busy SHALL be 1 in CAPTURE and DONE, 0 in IDLE.
REQ-028 start while in CAPTURE or DONE SHALL be ignored.
REQ-029 abort in CAPTURE -> IDLE on next edge; no frame_done; wr_count holds partial count; a write from an acceptance on the abort edge still completes.
REQ-030 abort in DONE SHALL be ignored; frame_done still pulses.
REQ-031 s_valid=1 while s_ready=0 SHALL set overrun on the next edge; cleared only by reset or entry to CAPTURE.
REQ-032 Gaps in s_valid during CAPTURE SHALL stall the address with no write and no error.
REQ-033 Address SHALL never wrap within a frame; ram_ada maximum is DEPTH-1.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE, s_ready=0, ram_cea=0, ram_ada=0, ram_din=0, busy=0, frame_done=0, wr_count=0, overrun=0.
REQ-035 Reset mid-capture SHALL drop ram_cea asynchronously; partial frame is abandoned, no frame_done.
REQ-036 After rst_n deasserts, first start SHALL be honoured on the first clock edge.

Verification
REQ-037 start, then 512 back-to-back samples 0x0000..0x01FF -> 512 writes ada=k din=k, frame_done single pulse with final write, wr_count=512, busy=0 one cycle later.
REQ-038 start, samples with s_valid toggling every other cycle -> 512 writes, consecutive addresses, no skips, frame completes after 1023 valid-window cycles, overrun=0.
REQ-039 start, 100 samples, abort -> IDLE next cycle, wr_count=100, no frame_done, subsequent s_valid sets overrun=1; next start clears overrun and wr_count to 0.
REQ-040 s_valid=1 with s_data=0x7FFF in IDLE -> no ram_cea, overrun=1; start and abort same cycle in IDLE -> remains IDLE.
REQ-041 rst_n asserted at sample 300 -> all outputs zero asynchronously; after release, start and full frame -> writes begin at ada=0.
REQ-042 start pulsed again at sample 200 and at DONE cycle -> ignored; frame finishes at ada=511 with one frame_done.
